vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing.sv | 81 ++++++++
 rtl/vga_scanout.sv | 104 ++++++++++
 tb/tb_vga_scanout.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer constants: 640x480@60 timing defaults and the 160x120 framebuffer geometry.
// The framebuffer address helper is shared with the plotter so both sides agree on layout.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned FB_WIDTH  = 160;
    localparam int unsigned FB_HEIGHT = 120;
    localparam int unsigned FB_ADDR_W = 15;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;

    // y*160 + x built from shifts: (y<<7)+(y<<5)+x, max 19199 fits in 15 bits
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] w_y;
        w_y = FB_ADDR_W'(y);
        return (w_y << 7) + (w_y << 5) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate timing core: clk/2 phase, h/v raster counters and active/sync decode.
// All raster state advances only on the pix_en edge (phase==1).
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    output logic           o_phase,
    output logic           o_pix_en,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_active,
    output logic           o_hs_n,
    output logic           o_vs_n,
    output logic           o_frame_wrap
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             r_phase;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_pix_en;

    assign w_pix_en = r_phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_active     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        o_hs_n       = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
        o_vs_n       = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
        o_frame_wrap = w_pix_en && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    end

    // 4x upscale: each framebuffer texel covers 4x4 screen pixels
    assign o_x      = r_h_cnt[9:2];
    assign o_y      = r_v_cnt[8:2];
    assign o_phase  = r_phase;
    assign o_pix_en = w_pix_en;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: framebuffer read addressing plus the registered DAC/sync output stage.
// Sync, blank and colour are registered together on pix_en so they stay aligned (1 pixel latency).
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [FB_ADDR_W-1:0] rd_addr,
    input  logic [2:0]           rd_data,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic                 vga_sync_n,
    output logic                 vga_clk,
    output logic                 frame_start
);

    logic           w_phase;
    logic           w_pix_en;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           w_active;
    logic           w_hs_n;
    logic           w_vs_n;
    logic           w_frame_wrap;

    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;
    logic       r_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk),
        .resetn       (resetn),
        .o_phase      (w_phase),
        .o_pix_en     (w_pix_en),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_active     (w_active),
        .o_hs_n       (w_hs_n),
        .o_vs_n       (w_vs_n),
        .o_frame_wrap (w_frame_wrap)
    );

    assign rd_addr = w_active ? fb_addr(w_x, w_y) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            // cleared on the following non-pix_en edge, giving a one-clk pulse
            r_frame_start <= w_frame_wrap;
            if (w_pix_en) begin
                r_hs      <= w_hs_n;
                r_vs      <= w_vs_n;
                r_blank_n <= w_active;
                r_r       <= w_active ? {8{rd_data[2]}} : '0;
                r_g       <= w_active ? {8{rd_data[1]}} : '0;
                r_b       <= w_active ? {8{rd_data[0]}} : '0;
            end
        end
    end

    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = w_phase;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a short-frame instance for timing/colour/reset,
// and a default-geometry instance (held in reset) for extreme framebuffer addresses.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  rd_data;
    logic [14:0] rd_addr;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

    logic        resetn_f;
    logic [2:0]  rd_data_f;
    logic [14:0] rd_addr_f;
    logic [7:0]  r_f, g_f, b_f;
    logic        hs_f, vs_f, blank_n_f, sync_n_f, vclk_f, fs_f;

    int n_cmp  = 0;
    int n_err  = 0;
    int rel    = 0;
    int fs_cnt = 0;

    always #10 clk = ~clk;

    // 800 x 15 raster: frame = 12000 pixels = 24000 clk; vs low for v in [10,12)
    vga_scanout #(
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_clk     (vga_clk),
        .frame_start (frame_start)
    );

    vga_scanout u_full (
        .clk         (clk),
        .resetn      (resetn_f),
        .rd_addr     (rd_addr_f),
        .rd_data     (rd_data_f),
        .vga_r       (r_f),
        .vga_g       (g_f),
        .vga_b       (b_f),
        .vga_hs      (hs_f),
        .vga_vs      (vs_f),
        .vga_blank_n (blank_n_f),
        .vga_sync_n  (sync_n_f),
        .vga_clk     (vclk_f),
        .frame_start (fs_f)
    );

    // clk edges since reset release; pixel k completes at edge 2*(k+1)
    always @(posedge clk or negedge resetn) begin
        if (!resetn) rel <= 0;
        else         rel <= rel + 1;
    end

    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic to_edge(input int e);
        while (rel < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"},      32'(vga_hs),      1);
        check({tag, "_vs"},      32'(vga_vs),      1);
        check({tag, "_blank_n"}, 32'(vga_blank_n), 0);
        check({tag, "_rgb"},     {8'h0, vga_r, vga_g, vga_b}, 0);
        check({tag, "_rd_addr"}, 32'(rd_addr),     0);
        check({tag, "_vga_clk"}, 32'(vga_clk),     0);
        check({tag, "_fs"},      32'(frame_start), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, got no end, expected end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        rd_data   = 3'b101;
        resetn_f  = 1'b0;
        rd_data_f = 3'b000;
        repeat (3) @(negedge clk);

        check_reset_outputs("rst");
        check("rst_sync_n", 32'(vga_sync_n), 0);
        check("full_rst_hs", 32'(hs_f), 1);
        check("full_rst_blank_n", 32'(blank_n_f), 0);

        force u_full.u_timing.r_h_cnt = 10'd639;
        force u_full.u_timing.r_v_cnt = 10'd479;
        #1 check("addr_639_479", 32'(rd_addr_f), 19199);
        force u_full.u_timing.r_h_cnt = 10'd4;
        force u_full.u_timing.r_v_cnt = 10'd4;
        #1 check("addr_4_4_full", 32'(rd_addr_f), 161);
        force u_full.u_timing.r_h_cnt = 10'd640;
        force u_full.u_timing.r_v_cnt = 10'd479;
        #1 check("addr_640_479", 32'(rd_addr_f), 0);
        force u_full.u_timing.r_h_cnt = 10'd639;
        force u_full.u_timing.r_v_cnt = 10'd480;
        #1 check("addr_639_480", 32'(rd_addr_f), 0);
        release u_full.u_timing.r_h_cnt;
        release u_full.u_timing.r_v_cnt;

        @(negedge clk);
        resetn = 1'b1;

        to_edge(1);
        check("rel1_vga_clk", 32'(vga_clk), 1);
        check("rel1_blank_n", 32'(vga_blank_n), 0);
        to_edge(2);
        check("rel2_blank_n", 32'(vga_blank_n), 1);
        check("rel2_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'hFF00FF);
        check("rel2_hs", 32'(vga_hs), 1);
        check("rel2_vga_clk", 32'(vga_clk), 0);

        to_edge(1278);
        check("addr_639_0", 32'(rd_addr), 159);
        to_edge(1280);
        check("addr_640_0", 32'(rd_addr), 0);
        check("blank_n_639", 32'(vga_blank_n), 1);
        to_edge(1282);
        check("blank_n_640", 32'(vga_blank_n), 0);
        check("rgb_640", {8'h0, vga_r, vga_g, vga_b}, 0);

        to_edge(1312);  check("hs_655", 32'(vga_hs), 1);
        to_edge(1314);  check("hs_656", 32'(vga_hs), 0);
        to_edge(1504);  check("hs_751", 32'(vga_hs), 0);
        to_edge(1506);  check("hs_752", 32'(vga_hs), 1);
        to_edge(2912);  check("hs_l1_655", 32'(vga_hs), 1);
        to_edge(2914);  check("hs_l1_656", 32'(vga_hs), 0);

        to_edge(6408);
        check("addr_4_4", 32'(rd_addr), 161);
        check("rgb_101", {8'h0, vga_r, vga_g, vga_b}, 32'hFF00FF);
        rd_data = 3'b010;
        to_edge(6410);
        check("rgb_010", {8'h0, vga_r, vga_g, vga_b}, 32'h00FF00);

        to_edge(16000); check("vs_v9", 32'(vga_vs), 1);
        to_edge(16002);
        check("vs_v10", 32'(vga_vs), 0);
        check("vblank_blank_n", 32'(vga_blank_n), 0);
        check("vblank_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
        to_edge(19200); check("vs_v11_end", 32'(vga_vs), 0);
        to_edge(19202); check("vs_v12", 32'(vga_vs), 1);

        to_edge(23999); check("fs_pre", 32'(frame_start), 0);
        to_edge(24000);
        check("fs_frame1", 32'(frame_start), 1);
        check("addr_wrap", 32'(rd_addr), 0);
        to_edge(24001); check("fs_frame1_width", 32'(frame_start), 0);
        to_edge(47999); check("fs_pre2", 32'(frame_start), 0);
        to_edge(48000); check("fs_frame2", 32'(frame_start), 1);
        to_edge(48001);
        check("fs_frame2_width", 32'(frame_start), 0);
        check("fs_count", 32'(fs_cnt), 2);

        to_edge(56101);
        check("mid_blank_n", 32'(vga_blank_n), 1);
        check("mid_vga_clk", 32'(vga_clk), 1);
        check("mid_addr", 32'(rd_addr), 172);
        check("mid_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h00FF00);
        resetn = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (4) @(negedge clk);
        check("midrst_fs_count", 32'(fs_cnt), 2);
        resetn = 1'b1;

        to_edge(1);
        check("resume1_blank_n", 32'(vga_blank_n), 0);
        to_edge(2);
        check("resume2_blank_n", 32'(vga_blank_n), 1);
        check("resume2_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h00FF00);
        to_edge(8);
        check("resume_addr_4_0", 32'(rd_addr), 1);
        to_edge(1314);
        check("resume_hs_656", 32'(vga_hs), 0);
        check("resume_fs_count", 32'(fs_cnt), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
